// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, cause codes, operation encoding and mstatus bit indices
package csr_pkg;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_e;
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIP_MTIP     = 7;
  localparam logic [30:0] CAUSE_EBREAK = 31'd3;
  localparam logic [30:0] CAUSE_MTI    = 31'd7;
  localparam logic [30:0] CAUSE_ECALL  = 31'd11;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with increment enable and 32-bit half-write port
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);
  logic [63:0] cnt_q, cnt_d;
  // a half write wins over the increment in the same cycle
  always_comb begin
    cnt_d = wr_lo ? {cnt_q[63:32], wdata} :
            wr_hi ? {wdata, cnt_q[31:0]} :
            inc   ? cnt_q + 64'd1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign value = cnt_q;
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with trap, mret and timer-interrupt handling
module csr_file
  import csr_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
  parameter bit              HAS_COUNTERS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_wbu,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            is_ecall,
  input  logic            is_ebreak,
  input  logic            is_mret,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] next_pc,
  input  logic            timer_irq,
  output logic [XLEN-1:0] rdata,
  output logic            illegal,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);
  logic mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [63:0] mcycle, minstret;
  logic mapped, wr_intent, commit, trap, do_mret, do_write, take_irq;
  logic [XLEN-1:0] old, wval;
  always_comb begin
    old = '0;
    mapped = 1'b1;
    case (addr)
      A_MSTATUS: begin
        old[12:11] = 2'b11;
        old[MSTATUS_MPIE] = mpie_q;
        old[MSTATUS_MIE] = mie_q;
      end
      A_MIE:       old[MIE_MTIE] = mtie_q;
      A_MTVEC:     old = mtvec_q;
      A_MSCRATCH:  old = mscratch_q;
      A_MEPC:      old = mepc_q;
      A_MCAUSE:    old = mcause_q;
      A_MIP:       old[MIP_MTIP] = timer_irq;
      A_MCYCLE:    begin old = mcycle[31:0];    mapped = HAS_COUNTERS; end
      A_MCYCLEH:   begin old = mcycle[63:32];   mapped = HAS_COUNTERS; end
      A_MINSTRET:  begin old = minstret[31:0];  mapped = HAS_COUNTERS; end
      A_MINSTRETH: begin old = minstret[63:32]; mapped = HAS_COUNTERS; end
      A_MVENDORID, A_MARCHID: old = '0;
      default:     mapped = 1'b0;
    endcase
  end
  assign rdata     = old;
  assign wr_intent = csr_op == OP_RW || (csr_op != OP_NONE && wdata != '0);
  assign illegal   = csr_op != OP_NONE && (!mapped || (wr_intent && addr[11:10] == 2'b11));
  assign commit    = valid_wbu && !illegal;
  assign trap      = commit && (is_ecall || is_ebreak);
  assign do_mret   = commit && !trap && is_mret;
  assign do_write  = commit && wr_intent && !trap && !is_mret;
  assign wval      = csr_op == OP_RW ? wdata : csr_op == OP_RS ? old | wdata : old & ~wdata;
  // the CSR write lands first; an interrupt then sees and overrides the written state
  always_comb begin
    mie_d = mie_q;
    mpie_d = mpie_q;
    mtie_d = mtie_q;
    mtvec_d = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d = mepc_q;
    mcause_d = mcause_q;
    redirect_pc_d = redirect_pc_q;
    if (do_write) begin
      case (addr)
        A_MSTATUS:  begin mie_d = wval[MSTATUS_MIE]; mpie_d = wval[MSTATUS_MPIE]; end
        A_MIE:      mtie_d = wval[MIE_MTIE];
        A_MTVEC:    mtvec_d = {wval[XLEN-1:2], wval[1] ? mtvec_q[1:0] : wval[1:0]};
        A_MSCRATCH: mscratch_d = wval;
        A_MEPC:     mepc_d = {wval[XLEN-1:1], 1'b0};
        A_MCAUSE:   mcause_d = wval;
        default:    ;
      endcase
    end
    take_irq = commit && !trap && !is_mret && mie_d && mtie_d && timer_irq;
    redirect_d = trap || do_mret || take_irq;
    if (trap) begin
      mepc_d = {pc[XLEN-1:1], 1'b0};
      mcause_d = {1'b0, is_ecall ? CAUSE_ECALL : CAUSE_EBREAK};
      mpie_d = mie_q;
      mie_d = 1'b0;
      redirect_pc_d = {mtvec_q[XLEN-1:2], 2'b00};
    end else if (do_mret) begin
      mie_d = mpie_q;
      mpie_d = 1'b1;
      redirect_pc_d = mepc_q;
    end else if (take_irq) begin
      mepc_d = {next_pc[XLEN-1:1], 1'b0};
      mcause_d = {1'b1, CAUSE_MTI};
      mpie_d = mie_d;
      mie_d = 1'b0;
      redirect_pc_d = {mtvec_d[XLEN-1:2], 2'b00} +
                      (mtvec_d[1:0] == MTVEC_VECTORED ? XLEN'(4 * CAUSE_MTI) : '0);
    end
  end
  if (HAS_COUNTERS) begin : g_cnt
    csr_counter64 u_mcycle (
      .clk, .rst,
      .inc   (1'b1),
      .wr_lo (do_write && addr == A_MCYCLE),
      .wr_hi (do_write && addr == A_MCYCLEH),
      .wdata (wval),
      .value (mcycle)
    );
    csr_counter64 u_minstret (
      .clk, .rst,
      .inc   (commit && !trap),
      .wr_lo (do_write && addr == A_MINSTRET),
      .wr_hi (do_write && addr == A_MINSTRETH),
      .wdata (wval),
      .value (minstret)
    );
  end else begin : g_no_cnt
    assign mcycle = '0;
    assign minstret = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q <= 1'b0;
      mpie_q <= 1'b0;
      mtie_q <= 1'b0;
      mtvec_q <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      redirect_q <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      mie_q <= mie_d;
      mpie_q <= mpie_d;
      mtie_q <= mtie_d;
      mtvec_q <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      redirect_q <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end
  assign redirect = redirect_q;
  assign redirect_pc = redirect_pc_q;
endmodule
